sb_tx_serializer: RTL and testbench
===================================

# sb_tx_serializer

Sideband transmit serializer for the UCIe logical PHY. It accepts one `SB_msg_t` sideband message (plus an optional 64-bit data payload) from an LTSM state block through the `SB_TX_*` handshake, and serializes it LSB-first onto the sideband TX data pin with a gated, forwarded sideband clock. It enforces the 32 UI inter-packet dead time and tells the LTSM when the next message may be offered. It is the pin-side counterpart of the message port that LTSM states such as SBINIT drive.

## Interface
- `DEAD_UI`, 32, idle UIs (clock low, data low) after every 64-bit packet
- `clk_800MHz`  in  1  sole clock; 1 UI = 2 cycles
- `reset`  in  1  asynchronous, active-high
- `enable_i`  in  1  block enable; low aborts any transfer
- `SB_TX_msg_i`  in  `SB_msg_t` (64 bits packed)  message header
- `SB_TX_dataBus_i`  in  64  payload, used only when `opcode == Message_with_64b_Data`
- `SB_TX_msg_valid_i`  in  1  message offered
- `SB_TX_msg_sendNextFlag_o`  out  1  ready: a message is captured when valid and ready are both high on a rising edge
- `SB_clkPin_TX_o`  out  1  forwarded sideband clock, gated
- `SB_dataPin_TX_o`  out  1  serial data
- `busy_o`  out  1  high in every state except IDLE
- `pkt_sent_o`  out  1  one-cycle pulse when the final dead time of a message ends

## Operation
- Clocking and reset: one clock, `clk_800MHz`. Reset is asynchronous and active-high.
- States: IDLE, HDR, GAP_H, DATA, GAP_D.
- Counters:
  - `bit_cnt`: 6 bits.
  - `phase`: 1 bit. 0 = first half of the UI, 1 = second half.
  - `gap_cnt`: counts UIs, from 0 to `DEAD_UI`-1.
- IDLE:
  - `sendNextFlag_o` = `enable_i`.
  - On capture, register the header and payload. Set `has_data` = (opcode == `Message_with_64b_Data`). Go to HDR with `bit_cnt`=0 and `phase`=0.
- HDR and DATA:
  - Data pin = shift register bit `bit_cnt`, LSB first. It is stable for both phases.
  - Clock pin = `phase`: low in the first half of the UI, high in the second half. The receiver samples on the rising edge.
  - `bit_cnt` increments when `phase`=1.
  - After bit 63, phase 1: HDR goes to GAP_H; DATA goes to GAP_D.
- GAP_H and GAP_D:
  - Both pins are low for `DEAD_UI` UIs.
  - At the end, GAP_H goes to DATA if `has_data`, otherwise to IDLE.
  - GAP_D always goes to IDLE.
  - The transition to IDLE pulses `pkt_sent_o`.
- Input hold: inputs are ignored outside the capture cycle. The LTSM may hold valid high across multiple 800 MHz cycles. Only the first cycle is captured, because ready drops on the following cycle.
- `enable_i` low in any state: next edge goes to IDLE. Pins go low, ready stays low, no `pkt_sent_o`, and the partial packet is discarded.
- `reset` mid-transfer: outputs go low immediately (asynchronous), and the state goes to IDLE.
- Reset values: all outputs 0. State IDLE. Counters 0. Shift registers 0.

## Timing
- All outputs are registered.
- Capture edge = E:
  - Bit 0 is on the data pin from E+1, with the clock pin low.
  - Clock pin high at E+2.
  - Bit k occupies cycles E+1+2k and E+2+2k.
- Header-only message:
  - Header ends at E+128.
  - Gap covers E+129 to E+192.
  - `pkt_sent_o` pulses and `sendNextFlag_o` rises at E+193. The next capture is possible at E+193.
- Message with data:
  - DATA bit 0 at E+193.
  - GAP_D covers E+321 to E+384.
  - `pkt_sent_o` and ready at E+385.
- Sustained header-only rate: 1 message per 193 cycles when valid is held.
- The clock pin never toggles during the gaps or in IDLE.

## Configuration
- `SB_TX_DATA_EN` defined:
  - Data packets are supported as described above.
- `SB_TX_DATA_EN` undefined:
  - `has_data` is forced to 0 and `SB_TX_dataBus_i` is unused.
  - Every message is header plus gap only.
  - The DATA and GAP_D states and the 64-bit payload register are not built.

## Test plan
- Header only: reset, enable, offer `msg_num=SBINIT_out_of_reset`, `opcode=Message_without_Data` at E.
  - Capture 64 bits on clock-pin rising edges; they must equal the packed header, LSB first.
  - Clock and data pins low E+129 to E+192; `pkt_sent_o` and ready at E+193.
- With data (macro on): offer `opcode=Message_with_64b_Data`, payload `64'hDEAD_BEEF_0123_4567`.
  - Header, then 64-UI gap, then payload bits from E+193, LSB first.
  - `pkt_sent_o` at E+385.
  - With the macro off, the same stimulus gives header only and `pkt_sent_o` at E+193.
- Valid held high for 16 cycles with a constant message: exactly one packet is sent, and a second capture occurs at E+193.
- `enable_i` dropped at E+40: pins are 0 from E+41, state is IDLE, there is no `pkt_sent_o`, and ready rises when `enable_i` returns.
- `reset` asserted at E+150 (mid-gap): all outputs are 0 immediately. After release with enable high, ready = 1 on the first edge.
- Back-to-back sequence `SBINIT_done_req` then `SBINIT_done_resp`: the two packets are separated by exactly 64 cycles of low pins, and both headers decode correctly.

Source files
------------

// File: rtl/sb_tx_serializer_if.sv
// Sideband TX message port between an LTSM state block and the pin-side serializer.
// SB_msg_t carries the 64-bit sideband header; opcode occupies bits [4:0].
interface sb_tx_serializer_if;
   typedef struct packed {
      logic        dp;
      logic        cp;
      logic [2:0]  dst_id;
      logic [2:0]  src_id;
      logic [15:0] msg_info;
      logic [7:0]  msg_num;
      logic [26:0] rsvd;
      logic [4:0]  opcode;
   } SB_msg_t;

   logic        enable_i;
   SB_msg_t     SB_TX_msg_i;
   logic [63:0] SB_TX_dataBus_i;
   logic        SB_TX_msg_valid_i;
   logic        SB_TX_msg_sendNextFlag_o;
   logic        SB_clkPin_TX_o;
   logic        SB_dataPin_TX_o;
   logic        busy_o;
   logic        pkt_sent_o;

   modport master (
      output enable_i, SB_TX_msg_i, SB_TX_dataBus_i, SB_TX_msg_valid_i,
      input  SB_TX_msg_sendNextFlag_o, SB_clkPin_TX_o, SB_dataPin_TX_o, busy_o, pkt_sent_o
   );

   modport slave (
      input  enable_i, SB_TX_msg_i, SB_TX_dataBus_i, SB_TX_msg_valid_i,
      output SB_TX_msg_sendNextFlag_o, SB_clkPin_TX_o, SB_dataPin_TX_o, busy_o, pkt_sent_o
   );
endinterface

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: 64-bit header (optionally followed by a 64-bit payload when
// SB_TX_DATA_EN is defined) sent LSB-first with a gated forwarded clock, 1 UI = 2 cycles.
//
// state | meaning
// IDLE  | ready = enable_i, waiting for a message
// HDR   | shifting out the 64 header bits
// GAP_H | DEAD_UI idle UIs after the header
// DATA  | shifting out the 64 payload bits
// GAP_D | DEAD_UI idle UIs after the payload
module sb_tx_serializer #(
   parameter int unsigned DEAD_UI = 32
) (
   input logic               clk_800MHz,
   input logic               reset,
   sb_tx_serializer_if.slave bus
);
   localparam logic [4:0]       OP_MSG_WITH_64B_DATA = 5'b11011;
   localparam int unsigned      GAP_W    = (DEAD_UI > 1) ? $clog2(DEAD_UI) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DEAD_UI - 1);

   typedef enum logic [2:0] {IDLE, HDR, GAP_H, DATA, GAP_D} state_t;

   state_t           state_q, state_d;
   logic [5:0]       bit_cnt_q, bit_cnt_d;
   logic             phase_q, phase_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [63:0]      hdr_q, hdr_d;
   logic             has_data_q, has_data_d;
   logic             ready_q, ready_d;
   logic             clk_pin_q, clk_pin_d;
   logic             data_pin_q, data_pin_d;
   logic             busy_q, busy_d;
   logic             pkt_sent_q, pkt_sent_d;
`ifdef SB_TX_DATA_EN
   logic [63:0]      pay_q, pay_d;
`endif

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      phase_d    = phase_q;
      gap_cnt_d  = gap_cnt_q;
      hdr_d      = hdr_q;
      has_data_d = has_data_q;
`ifdef SB_TX_DATA_EN
      pay_d      = pay_q;
`endif
      pkt_sent_d = 1'b0;

      // Disable wins over everything: the partial packet is dropped without a pkt_sent pulse.
      if (!bus.enable_i) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         phase_d   = 1'b0;
         gap_cnt_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.SB_TX_msg_valid_i && ready_q) begin
                  hdr_d      = bus.SB_TX_msg_i;
`ifdef SB_TX_DATA_EN
                  pay_d      = bus.SB_TX_dataBus_i;
                  has_data_d = (bus.SB_TX_msg_i.opcode == OP_MSG_WITH_64B_DATA);
`else
                  has_data_d = 1'b0;
`endif
                  state_d    = HDR;
                  bit_cnt_d  = '0;
                  phase_d    = 1'b0;
               end
            end
            HDR, DATA: begin
               phase_d = ~phase_q;
               if (phase_q) begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_q == 6'd63) begin
                     gap_cnt_d = '0;
                     state_d   = (state_q == HDR) ? GAP_H : GAP_D;
                  end
               end
            end
            GAP_H, GAP_D: begin
               phase_d = ~phase_q;
               if (phase_q) begin
                  gap_cnt_d = gap_cnt_q + GAP_W'(1);
                  if (gap_cnt_q == GAP_LAST) begin
                     gap_cnt_d = '0;
                     bit_cnt_d = '0;
                     if ((state_q == GAP_H) && has_data_q) begin
                        state_d = DATA;
                     end else begin
                        state_d    = IDLE;
                        pkt_sent_d = 1'b1;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Pins are computed from next-state values so they are registered yet aligned with the state.
      ready_d    = (state_d == IDLE) && bus.enable_i;
      busy_d     = (state_d != IDLE);
      clk_pin_d  = ((state_d == HDR) || (state_d == DATA)) && phase_d;
      data_pin_d = 1'b0;
      if (state_d == HDR) begin
         data_pin_d = hdr_d[bit_cnt_d];
      end
`ifdef SB_TX_DATA_EN
      else if (state_d == DATA) begin
         data_pin_d = pay_d[bit_cnt_d];
      end
`endif
   end

   always_ff @(posedge clk_800MHz or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         phase_q    <= 1'b0;
         gap_cnt_q  <= '0;
         hdr_q      <= '0;
         has_data_q <= 1'b0;
         ready_q    <= 1'b0;
         clk_pin_q  <= 1'b0;
         data_pin_q <= 1'b0;
         busy_q     <= 1'b0;
         pkt_sent_q <= 1'b0;
`ifdef SB_TX_DATA_EN
         pay_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         phase_q    <= phase_d;
         gap_cnt_q  <= gap_cnt_d;
         hdr_q      <= hdr_d;
         has_data_q <= has_data_d;
         ready_q    <= ready_d;
         clk_pin_q  <= clk_pin_d;
         data_pin_q <= data_pin_d;
         busy_q     <= busy_d;
         pkt_sent_q <= pkt_sent_d;
`ifdef SB_TX_DATA_EN
         pay_q      <= pay_d;
`endif
      end
   end

   assign bus.SB_TX_msg_sendNextFlag_o = ready_q;
   assign bus.SB_clkPin_TX_o           = clk_pin_q;
   assign bus.SB_dataPin_TX_o          = data_pin_q;
   assign bus.busy_o                   = busy_q;
   assign bus.pkt_sent_o               = pkt_sent_q;
endmodule

// File: tb/tb_sb_tx_serializer.sv
// Bench for sb_tx_serializer: decodes the pins on forwarded-clock rising edges and
// compares each 64-bit word against a queue of expected words pushed at capture.
`timescale 1ns/1ps
module tb_sb_tx_serializer;
   localparam logic [4:0] OP_NO_DATA = 5'b10010;
   localparam logic [4:0] OP_DATA    = 5'b11011;
   localparam logic [7:0] SBINIT_OUT_OF_RESET = 8'h91;
   localparam logic [7:0] SBINIT_DONE_REQ     = 8'h95;
   localparam logic [7:0] SBINIT_DONE_RESP    = 8'h9A;
`ifdef SB_TX_DATA_EN
   localparam bit DATA_ON = 1'b1;
`else
   localparam bit DATA_ON = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [7:0]  msg_num;
      logic [4:0]  opcode;
      logic [15:0] info;
      logic [63:0] payload;
      int          exp_done;
   } vec_t;

   logic clk_800MHz = 1'b0;
   logic reset;
   int   cyc;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [63:0] exp_q[$];

   sb_tx_serializer_if bus ();

   sb_tx_serializer dut (
      .clk_800MHz (clk_800MHz),
      .reset      (reset),
      .bus        (bus)
   );

   always #1 clk_800MHz = ~clk_800MHz;
   always @(posedge clk_800MHz) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] mk_hdr(input logic [7:0] num, input logic [4:0] op,
                                          input logic [15:0] info, input logic [63:0] pay);
      logic [63:0] h;
      h        = 64'h0;
      h[4:0]   = op;
      h[39:32] = num;
      h[55:40] = info;
      h[58:56] = 3'd1;
      h[61:59] = 3'd4;
      h[62]    = ^h[61:0];
      h[63]    = (op == OP_DATA) ? ^pay : 1'b0;
      return h;
   endfunction

   function automatic logic [4:0] outs();
      return {bus.SB_TX_msg_sendNextFlag_o, bus.SB_clkPin_TX_o, bus.SB_dataPin_TX_o,
              bus.busy_o, bus.pkt_sent_o};
   endfunction

   // Monitor: shifts the data pin in on each clock-pin rising edge; a dropped busy discards partials.
   initial begin : monitor
      logic        prev_clk;
      logic [63:0] sh;
      int          nb;
      prev_clk = 1'b0;
      sh       = 64'h0;
      nb       = 0;
      forever begin
         @(negedge clk_800MHz);
         if (bus.busy_o !== 1'b1) begin
            nb = 0;
         end else if (bus.SB_clkPin_TX_o === 1'b1 && prev_clk === 1'b0) begin
            sh = {bus.SB_dataPin_TX_o, sh[63:1]};
            nb++;
            if (nb == 64) begin
               nb = 0;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_pkt: got %h, expected no packet", sh);
               end else begin
                  check("pkt_word", sh, exp_q.pop_front());
               end
            end
         end
         prev_clk = bus.SB_clkPin_TX_o;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_m(input int e, input int m);
      while (cyc < e + m) @(negedge clk_800MHz);
   endtask

   // Called at a negedge; returns at the negedge just after the capture edge (m = 0).
   task automatic offer(input logic [63:0] hdr, input logic [63:0] pay, input bit push,
                        input bit hold, output int e);
      int t;
      bus.SB_TX_msg_i       = hdr;
      bus.SB_TX_dataBus_i   = pay;
      bus.SB_TX_msg_valid_i = 1'b1;
      t = 0;
      while (bus.SB_TX_msg_sendNextFlag_o !== 1'b1 && t < 500) begin
         @(negedge clk_800MHz);
         t++;
      end
      check("offer_ready_seen", 64'(t < 500), 64'd1);
      @(posedge clk_800MHz);
      if (push) begin
         exp_q.push_back(hdr);
         if (DATA_ON && hdr[4:0] == OP_DATA) exp_q.push_back(pay);
      end
      @(negedge clk_800MHz);
      e = cyc;
      if (!hold) bus.SB_TX_msg_valid_i = 1'b0;
   endtask

   task automatic run_pkt(input string nm, input int e, input int done,
                          input logic [63:0] hdr, input logic [63:0] pay);
      int gap_bad, pulse_bad, ready_bad, busy_bad;
      bit in_gap;
      gap_bad = 0; pulse_bad = 0; ready_bad = 0; busy_bad = 0;
      for (int m = 0; m <= done; m++) begin
         wait_m(e, m);
         in_gap = (m >= 128 && m < 192) || (done == 384 && m >= 320 && m < 384);
         if (in_gap && (bus.SB_clkPin_TX_o !== 1'b0 || bus.SB_dataPin_TX_o !== 1'b0)) gap_bad++;
         if (m < done && bus.pkt_sent_o !== 1'b0) pulse_bad++;
         if (m < done && bus.SB_TX_msg_sendNextFlag_o !== 1'b0) ready_bad++;
         if (m < done && bus.busy_o !== 1'b1) busy_bad++;
         if (m == 0) check({nm, "_bit0_clk_data"}, {bus.SB_clkPin_TX_o, bus.SB_dataPin_TX_o}, {1'b0, hdr[0]});
         if (m == 1) check({nm, "_first_clk_high"}, bus.SB_clkPin_TX_o, 1'b1);
         if (m == 192 && done == 384)
            check({nm, "_pay_bit0_clk_data"}, {bus.SB_clkPin_TX_o, bus.SB_dataPin_TX_o}, {1'b0, pay[0]});
      end
      check({nm, "_gap_pins_low"}, gap_bad, 0);
      check({nm, "_no_early_pkt_sent"}, pulse_bad, 0);
      check({nm, "_no_early_ready"}, ready_bad, 0);
      check({nm, "_busy_while_sending"}, busy_bad, 0);
      check({nm, "_done_ready_sent_busy"},
            {bus.SB_TX_msg_sendNextFlag_o, bus.pkt_sent_o, bus.busy_o}, 3'b110);
      check({nm, "_words_drained"}, exp_q.size(), 0);
   endtask

   initial begin : stim
      vec_t        vecs[4];
      logic [63:0] hdr;
      int          e, e2, e_prev, prev_done, bad;

      vecs[0] = '{"oor_nodata",  SBINIT_OUT_OF_RESET, OP_NO_DATA, 16'hA5C3, 64'h0, 192};
      vecs[1] = '{"oor_data",    SBINIT_OUT_OF_RESET, OP_DATA,    16'h1234,
                  64'hDEAD_BEEF_0123_4567, DATA_ON ? 384 : 192};
      vecs[2] = '{"done_req",    SBINIT_DONE_REQ,     OP_NO_DATA, 16'h0001, 64'h0, 192};
      vecs[3] = '{"done_resp",   SBINIT_DONE_RESP,    OP_NO_DATA, 16'hFFFF, 64'h0, 192};

      reset                 = 1'b1;
      bus.enable_i          = 1'b0;
      bus.SB_TX_msg_valid_i = 1'b0;
      bus.SB_TX_msg_i       = '0;
      bus.SB_TX_dataBus_i   = '0;
      repeat (3) @(negedge clk_800MHz);
      check("reset_outputs", outs(), 5'b0);
      bus.enable_i = 1'b1;
      @(negedge clk_800MHz);
      check("reset_held_enabled", outs(), 5'b0);
      reset = 1'b0;
      @(negedge clk_800MHz);
      check("ready_after_reset", outs(), 5'b10000);

      // Table: each message is offered the moment ready returns, so they run back to back.
      e_prev = 0; prev_done = 0;
      for (int i = 0; i < 4; i++) begin
         hdr = mk_hdr(vecs[i].msg_num, vecs[i].opcode, vecs[i].info, vecs[i].payload);
         offer(hdr, vecs[i].payload, 1'b1, 1'b0, e);
         if (i > 0) check({vecs[i].name, "_spacing"}, e - e_prev, prev_done + 1);
         run_pkt(vecs[i].name, e, vecs[i].exp_done, hdr, vecs[i].payload);
         e_prev = e; prev_done = vecs[i].exp_done;
      end

      // Valid held for 16 cycles: one capture only, next capture at E+193.
      repeat (5) @(negedge clk_800MHz);
      hdr = mk_hdr(SBINIT_DONE_REQ, OP_NO_DATA, 16'h5A5A, 64'h0);
      offer(hdr, 64'h0, 1'b1, 1'b1, e);
      bad = 0;
      for (int m = 1; m < 16; m++) begin
         wait_m(e, m);
         if (bus.SB_TX_msg_sendNextFlag_o !== 1'b0) bad++;
      end
      bus.SB_TX_msg_valid_i = 1'b0;
      check("hold_ready_low", bad, 0);
      wait_m(e, 192);
      check("hold_done_outs", outs(), 5'b10001);
      check("hold_one_packet", exp_q.size(), 0);
      hdr = mk_hdr(SBINIT_DONE_RESP, OP_NO_DATA, 16'h0F0F, 64'h0);
      offer(hdr, 64'h0, 1'b1, 1'b0, e2);
      check("hold_second_capture", e2 - e, 193);
      run_pkt("hold_second", e2, 192, hdr, 64'h0);

      // enable_i dropped at E+40: partial packet discarded, no pkt_sent.
      hdr = mk_hdr(SBINIT_OUT_OF_RESET, OP_NO_DATA, 16'hC0DE, 64'h0);
      offer(hdr, 64'h0, 1'b0, 1'b0, e);
      wait_m(e, 39);
      bus.enable_i = 1'b0;
      wait_m(e, 40);
      check("dis_outputs_low", outs(), 5'b0);
      bad = 0;
      for (int m = 41; m < 200; m++) begin
         wait_m(e, m);
         if (outs() !== 5'b0) bad++;
      end
      check("dis_stays_idle", bad, 0);
      bus.enable_i = 1'b1;
      @(negedge clk_800MHz);
      check("dis_ready_returns", outs(), 5'b10000);

      // reset at E+150, mid-gap: outputs clear without waiting for a clock edge.
      hdr = mk_hdr(SBINIT_DONE_REQ, OP_NO_DATA, 16'h7777, 64'h0);
      offer(hdr, 64'h0, 1'b1, 1'b0, e);
      wait_m(e, 149);
      check("rst_pre_gap_busy", outs(), 5'b00010);
      reset = 1'b1;
      #0.25;
      check("rst_async_outputs", outs(), 5'b0);
      @(negedge clk_800MHz);
      reset = 1'b0;
      @(negedge clk_800MHz);
      check("rst_release_ready", outs(), 5'b10000);
      repeat (50) @(negedge clk_800MHz);
      check("rst_no_stray_words", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
